// File: rtl/bidir_bus_pkg.sv
// Shared definitions for the bidirectional pad-bus controller:
// state encoding, timing-counter width and drive-direction flag values.
package bidir_bus_pkg;

    localparam int CNT_W = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_TURN    = 3'd1;
    localparam logic [2:0] ST_W_SETUP = 3'd2;
    localparam logic [2:0] ST_W_STB   = 3'd3;
    localparam logic [2:0] ST_W_HOLD  = 3'd4;
    localparam logic [2:0] ST_R_SETUP = 3'd5;
    localparam logic [2:0] ST_R_STB   = 3'd6;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/bidir_bus_ctrl.sv
// Core-side sequencer for a tristate parallel bus: setup/strobe/hold phases
// with released-bus turnaround cycles whenever the drive direction flips.
module bidir_bus_ctrl
    import bidir_bus_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int STB_CYCLES   = 2,
    parameter int TURN_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_we,
    output logic                  bus_stb,
    output logic [DATA_WIDTH-1:0] pad_i,
    output logic [DATA_WIDTH-1:0] pad_t,
    input  logic [DATA_WIDTH-1:0] pad_o
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LD   = CNT_W'(STB_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYCLES - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_dir;
    logic             w_accept;
    logic             w_cnt_done;
    logic             w_last_rstb;

    assign w_accept    = req_valid && req_ready;
    assign w_cnt_done  = (r_cnt == '0);
    assign w_last_rstb = (r_state == ST_R_STB) && w_cnt_done;

    // r_dir already holds the new direction while in TURN (updated at accept).
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_done ? r_cnt : r_cnt - 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (req_write != r_dir) begin
                        w_state_nxt = ST_TURN;
                        w_cnt_nxt   = TURN_LD;
                    end else begin
                        w_state_nxt = req_write ? ST_W_SETUP : ST_R_SETUP;
                        w_cnt_nxt   = SETUP_LD;
                    end
                end
            end
            ST_TURN: begin
                if (w_cnt_done) begin
                    w_state_nxt = (r_dir == DIR_WRITE) ? ST_W_SETUP : ST_R_SETUP;
                    w_cnt_nxt   = SETUP_LD;
                end
            end
            ST_W_SETUP: begin
                if (w_cnt_done) begin
                    w_state_nxt = ST_W_STB;
                    w_cnt_nxt   = STB_LD;
                end
            end
            ST_W_STB: begin
                if (w_cnt_done) begin
                    w_state_nxt = ST_W_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_W_HOLD: w_state_nxt = ST_IDLE;
            ST_R_SETUP: begin
                if (w_cnt_done) begin
                    w_state_nxt = ST_R_STB;
                    w_cnt_nxt   = STB_LD;
                end
            end
            ST_R_STB: begin
                if (w_cnt_done) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_dir     <= DIR_READ;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            bus_addr  <= '0;
            bus_we    <= 1'b0;
            bus_stb   <= 1'b0;
            pad_i     <= '0;
            pad_t     <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            req_ready <= (w_state_nxt == ST_IDLE);
            rsp_valid <= (w_state_nxt == ST_IDLE) && (r_state != ST_IDLE);
            bus_stb   <= (w_state_nxt inside {ST_W_STB, ST_R_STB});
            bus_we    <= (w_state_nxt inside {ST_W_SETUP, ST_W_STB, ST_W_HOLD});
            if (w_accept) begin
                r_dir    <= req_write;
                bus_addr <= req_addr;
                if (req_write) pad_i <= req_wdata;
            end
            // In IDLE pad_t is left alone: parked driven after a write, released after a read.
            if (w_state_nxt inside {ST_TURN, ST_R_SETUP, ST_R_STB})
                pad_t <= '1;
            else if (w_state_nxt inside {ST_W_SETUP, ST_W_STB, ST_W_HOLD})
                pad_t <= '0;
            if (w_last_rstb) rsp_rdata <= pad_o;
        end
    end

endmodule
